// File: rtl/arm7tdmi_pkg.sv
// Shared types for the ARM7TDMI debug-entry logic: sequencer states,
// debug entry causes and the priority encoder that picks a cause.
package arm7tdmi_pkg;

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_PEND    = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_HALTED  = 3'd3,
        ST_RESTART = 3'd4
    } dbg_state_e;

    typedef enum logic [2:0] {
        CAUSE_NONE  = 3'd0,
        CAUSE_BKPT  = 3'd1,
        CAUSE_WATCH = 3'd2,
        CAUSE_ICE   = 3'd3,
        CAUSE_EXT   = 3'd4
    } dbg_cause_e;

    // Highest-priority cause among the qualified requests (BKPT first).
    function automatic dbg_cause_e pick_cause(input logic bkpt, input logic watch,
                                              input logic ice, input logic ext);
        if (bkpt)       return CAUSE_BKPT;
        else if (watch) return CAUSE_WATCH;
        else if (ice)   return CAUSE_ICE;
        else if (ext)   return CAUSE_EXT;
        else            return CAUSE_NONE;
    endfunction

endpackage

// File: rtl/arm7tdmi_debug_sequencer.sv
// Debug-entry sequencer: qualifies debug requests, waits for an instruction
// boundary, drains the bus (with timeout), holds the core in debug state and
// releases it after a fixed restart synchronisation delay.
module arm7tdmi_debug_sequencer
    import arm7tdmi_pkg::*;
#(
    parameter int unsigned RESTART_SYNC  = 3,
    parameter int unsigned DRAIN_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       debug_en,
    input  logic       breakpoint,
    input  logic       watchpoint,
    input  logic       ice_req,
    input  logic       dbgrq,
    input  logic       debug_restart,
    input  logic       instr_done,
    input  logic       bus_idle,
    output logic       core_halt,
    output logic       dbgack,
    output logic [2:0] debug_cause,
    output logic [7:0] entry_count,
    output logic       drain_timeout
);

    localparam logic [3:0] RESTART_LOAD = 4'(RESTART_SYNC);
    localparam logic [7:0] DRAIN_LIMIT  = 8'(DRAIN_TIMEOUT);

    dbg_state_e state_q, state_d;
    dbg_cause_e cause_q, cause_d;
    dbg_cause_e req_cause;
    logic [7:0] drain_cnt_q, drain_cnt_d;
    logic [3:0] restart_cnt_q, restart_cnt_d;
    logic [7:0] entry_cnt_q, entry_cnt_d;
    logic       tmo_q, tmo_d;
    logic       halt_q, halt_d;
    logic       ack_q, ack_d;

    // Next-state, cause latch, counters; outputs derived from the next state
    // so the registered outputs line up with the state they describe.
    always_comb begin
        state_d       = state_q;
        cause_d       = cause_q;
        drain_cnt_d   = 8'd0;
        restart_cnt_d = 4'd0;
        entry_cnt_d   = entry_cnt_q;
        tmo_d         = tmo_q;
        req_cause     = pick_cause(breakpoint & debug_en, watchpoint & debug_en,
                                   ice_req, dbgrq);

        case (state_q)
            ST_RUN: begin
                if (req_cause != CAUSE_NONE) begin
                    cause_d = req_cause;
                    tmo_d   = 1'b0;
                    // Already at an instruction boundary: skip PEND.
                    state_d = instr_done ? ST_DRAIN : ST_PEND;
                end
            end
            ST_PEND: begin
                // A breakpoint already stalls the core, so no boundary is needed.
                if (instr_done || cause_q == CAUSE_BKPT) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                drain_cnt_d = drain_cnt_q + 8'd1;
                if (bus_idle) begin
                    state_d = ST_HALTED;
                end else if (drain_cnt_d == DRAIN_LIMIT) begin
                    state_d = ST_HALTED;
                    tmo_d   = 1'b1;
                end
            end
            ST_HALTED: begin
                if (debug_restart) begin
                    state_d       = ST_RESTART;
                    restart_cnt_d = RESTART_LOAD;
                end
            end
            ST_RESTART: begin
                restart_cnt_d = restart_cnt_q - 4'd1;
                if (restart_cnt_d == 4'd0) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase

        if (state_d == ST_HALTED && state_q != ST_HALTED && entry_cnt_q != 8'hFF)
            entry_cnt_d = entry_cnt_q + 8'd1;

        halt_d = (state_d == ST_DRAIN) || (state_d == ST_HALTED) ||
                 (state_d == ST_RESTART) ||
                 (state_d == ST_PEND && cause_d == CAUSE_BKPT);
        ack_d  = (state_d == ST_HALTED);
    end

    // Single state/output register bank with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            cause_q       <= CAUSE_NONE;
            drain_cnt_q   <= 8'd0;
            restart_cnt_q <= 4'd0;
            entry_cnt_q   <= 8'd0;
            tmo_q         <= 1'b0;
            halt_q        <= 1'b0;
            ack_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cause_q       <= cause_d;
            drain_cnt_q   <= drain_cnt_d;
            restart_cnt_q <= restart_cnt_d;
            entry_cnt_q   <= entry_cnt_d;
            tmo_q         <= tmo_d;
            halt_q        <= halt_d;
            ack_q         <= ack_d;
        end
    end

    assign core_halt     = halt_q;
    assign dbgack        = ack_q;
    assign debug_cause   = cause_q;
    assign entry_count   = entry_cnt_q;
    assign drain_timeout = tmo_q;

endmodule

// File: tb/tb_arm7tdmi_debug_sequencer.sv
// Scenario bench for the debug sequencer: expected output words are queued
// when stimulus is applied and compared after the clock edge that produces them.
module tb_arm7tdmi_debug_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       debug_en = 1'b0;
    logic       breakpoint = 1'b0;
    logic       watchpoint = 1'b0;
    logic       ice_req = 1'b0;
    logic       dbgrq = 1'b0;
    logic       debug_restart = 1'b0;
    logic       instr_done = 1'b0;
    logic       bus_idle = 1'b0;
    logic       core_halt;
    logic       dbgack;
    logic [2:0] debug_cause;
    logic [7:0] entry_count;
    logic       drain_timeout;

    typedef struct {
        logic [13:0] v;
        string       tag;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;

    arm7tdmi_debug_sequencer #(.RESTART_SYNC(3), .DRAIN_TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .debug_en(debug_en), .breakpoint(breakpoint),
        .watchpoint(watchpoint), .ice_req(ice_req), .dbgrq(dbgrq),
        .debug_restart(debug_restart), .instr_done(instr_done), .bus_idle(bus_idle),
        .core_halt(core_halt), .dbgack(dbgack), .debug_cause(debug_cause),
        .entry_count(entry_count), .drain_timeout(drain_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] obs();
        return {core_halt, dbgack, debug_cause, entry_count, drain_timeout};
    endfunction

    function automatic logic [13:0] pack(input logic h, input logic a, input logic [2:0] c,
                                         input int n, input logic t);
        return {h, a, c, 8'(n), t};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic h, input logic a, input logic [2:0] c,
                        input logic t, input string tag);
        exp_t x;
        x.v = pack(h, a, c, exp_cnt, t);
        x.tag = tag;
        sb.push_back(x);
    endtask

    // Stimulus-only release from HALTED back to RUN.
    task automatic do_restart();
        debug_restart = 1'b1;
        tick();
        debug_restart = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        push(0, 0, 3'd0, 0, "reset_state");
        tick();
        e = sb.pop_front(); checks++;
        if (obs() !== e.v) begin errors++; $display("FAIL %s actual=%h required=%h", e.tag, obs(), e.v); end
    endtask

    task automatic test_ext_entry();
        dbgrq = 1'b1; bus_idle = 1'b1;
        push(0, 0, 3'd4, 0, "ext_pend");
        push(0, 0, 3'd4, 0, "ext_pend_hold");
        for (int i = 0; i < 2; i++) begin
            tick();
            e = sb.pop_front(); checks++;
            if (obs() !== e.v) begin errors++; $display("FAIL %s actual=%h required=%h", e.tag, obs(), e.v); end
        end
        instr_done = 1'b1;
        push(1, 0, 3'd4, 0, "ext_drain");
        tick();
        instr_done = 1'b0;
        e = sb.pop_front(); checks++;
        if (obs() !== e.v) begin errors++; $display("FAIL %s actual=%h required=%h", e.tag, obs(), e.v); end
        exp_cnt = 1;
        push(1, 1, 3'd4, 0, "ext_halted");
        push(1, 1, 3'd4, 0, "halted_ignores_req");
        for (int i = 0; i < 2; i++) begin
            tick();
            e = sb.pop_front(); checks++;
            if (obs() !== e.v) begin errors++; $display("FAIL %s actual=%h required=%h", e.tag, obs(), e.v); end
        end
        dbgrq = 1'b0;
    endtask

    task automatic test_restart();
        debug_restart = 1'b1;
        push(1, 0, 3'd4, 0, "restart_ack_drop");
        push(1, 0, 3'd4, 0, "restart_cycle2");
        push(1, 0, 3'd4, 0, "restart_cycle3");
        push(0, 0, 3'd4, 0, "restart_release");
        for (int i = 0; i < 4; i++) begin
            tick();
            debug_restart = 1'b0;
            e = sb.pop_front(); checks++;
            if (obs() !== e.v) begin errors++; $display("FAIL %s actual=%h required=%h", e.tag, obs(), e.v); end
        end
    endtask

    task automatic test_bkpt();
        breakpoint = 1'b1; debug_en = 1'b1; dbgrq = 1'b1; bus_idle = 1'b1;
        push(1, 0, 3'd1, 0, "bkpt_halt_1cyc");
        tick();
        breakpoint = 1'b0; dbgrq = 1'b0;
        e = sb.pop_front(); checks++;
        if (obs() !== e.v) begin errors++; $display("FAIL %s actual=%h required=%h", e.tag, obs(), e.v); end
        push(1, 0, 3'd1, 0, "bkpt_drain_no_boundary");
        tick();
        e = sb.pop_front(); checks++;
        if (obs() !== e.v) begin errors++; $display("FAIL %s actual=%h required=%h", e.tag, obs(), e.v); end
        exp_cnt = 2;
        push(1, 1, 3'd1, 0, "bkpt_halted");
        tick();
        e = sb.pop_front(); checks++;
        if (obs() !== e.v) begin errors++; $display("FAIL %s actual=%h required=%h", e.tag, obs(), e.v); end
        debug_en = 1'b0;
        do_restart();
    endtask

    task automatic test_timeout();
        ice_req = 1'b1; instr_done = 1'b1; bus_idle = 1'b0;
        push(1, 0, 3'd3, 0, "ice_direct_drain");
        tick();
        ice_req = 1'b0; instr_done = 1'b0;
        e = sb.pop_front(); checks++;
        if (obs() !== e.v) begin errors++; $display("FAIL %s actual=%h required=%h", e.tag, obs(), e.v); end
        for (int i = 2; i <= 255; i++) begin
            push(1, 0, 3'd3, 0, "drain_wait");
            tick();
            e = sb.pop_front(); checks++;
            if (obs() !== e.v) begin errors++; $display("FAIL %s cycle=%0d actual=%h required=%h", e.tag, i, obs(), e.v); end
        end
        exp_cnt = 3;
        push(1, 1, 3'd3, 1, "drain_timeout_halt");
        tick();
        e = sb.pop_front(); checks++;
        if (obs() !== e.v) begin errors++; $display("FAIL %s actual=%h required=%h", e.tag, obs(), e.v); end
        do_restart();
        push(0, 0, 3'd3, 1, "timeout_sticky_in_run");
        tick();
        e = sb.pop_front(); checks++;
        if (obs() !== e.v) begin errors++; $display("FAIL %s actual=%h required=%h", e.tag, obs(), e.v); end
    endtask

    task automatic test_ignored();
        bus_idle = 1'b1; debug_en = 1'b0; watchpoint = 1'b1;
        push(0, 0, 3'd3, 1, "wp_disabled");
        push(0, 0, 3'd3, 1, "wp_disabled_after");
        for (int i = 0; i < 2; i++) begin
            tick();
            watchpoint = 1'b0;
            e = sb.pop_front(); checks++;
            if (obs() !== e.v) begin errors++; $display("FAIL %s actual=%h required=%h", e.tag, obs(), e.v); end
        end
        debug_restart = 1'b1;
        push(0, 0, 3'd3, 1, "restart_in_run");
        push(0, 0, 3'd3, 1, "restart_in_run_after");
        for (int i = 0; i < 2; i++) begin
            tick();
            debug_restart = 1'b0;
            e = sb.pop_front(); checks++;
            if (obs() !== e.v) begin errors++; $display("FAIL %s actual=%h required=%h", e.tag, obs(), e.v); end
        end
        debug_en = 1'b1; watchpoint = 1'b1;
        push(0, 0, 3'd2, 0, "wp_pulse_pend");
        push(0, 0, 3'd2, 0, "wp_pend_hold");
        for (int i = 0; i < 2; i++) begin
            tick();
            watchpoint = 1'b0;
            e = sb.pop_front(); checks++;
            if (obs() !== e.v) begin errors++; $display("FAIL %s actual=%h required=%h", e.tag, obs(), e.v); end
        end
        instr_done = 1'b1;
        push(1, 0, 3'd2, 0, "wp_drain");
        tick();
        instr_done = 1'b0;
        e = sb.pop_front(); checks++;
        if (obs() !== e.v) begin errors++; $display("FAIL %s actual=%h required=%h", e.tag, obs(), e.v); end
        exp_cnt = 4;
        push(1, 1, 3'd2, 0, "wp_halted");
        tick();
        e = sb.pop_front(); checks++;
        if (obs() !== e.v) begin errors++; $display("FAIL %s actual=%h required=%h", e.tag, obs(), e.v); end
        debug_en = 1'b0;
        do_restart();
    endtask

    task automatic test_rst_mid_drain();
        dbgrq = 1'b1; instr_done = 1'b1; bus_idle = 1'b0;
        push(1, 0, 3'd4, 0, "rst_drain_enter");
        tick();
        dbgrq = 1'b0; instr_done = 1'b0;
        e = sb.pop_front(); checks++;
        if (obs() !== e.v) begin errors++; $display("FAIL %s actual=%h required=%h", e.tag, obs(), e.v); end
        rst = 1'b1;
        exp_cnt = 0;
        push(0, 0, 3'd0, 0, "rst_mid_drain");
        tick();
        rst = 1'b0;
        e = sb.pop_front(); checks++;
        if (obs() !== e.v) begin errors++; $display("FAIL %s actual=%h required=%h", e.tag, obs(), e.v); end
    endtask

    // Requests held high across every restart: each return to RUN must
    // re-enter debug immediately; 256 entries saturate the counter.
    task automatic test_back_to_back();
        dbgrq = 1'b1; instr_done = 1'b1; bus_idle = 1'b1;
        for (int k = 0; k < 256; k++) begin
            tick();
            if (exp_cnt < 255) exp_cnt++;
            push(1, 1, 3'd4, 0, "b2b_entry");
            tick();
            e = sb.pop_front(); checks++;
            if (obs() !== e.v) begin errors++; $display("FAIL %s k=%0d actual=%h required=%h", e.tag, k, obs(), e.v); end
            debug_restart = 1'b1;
            tick();
            debug_restart = 1'b0;
            repeat (2) tick();
            push(0, 0, 3'd4, 0, "b2b_run");
            tick();
            e = sb.pop_front(); checks++;
            if (obs() !== e.v) begin errors++; $display("FAIL %s k=%0d actual=%h required=%h", e.tag, k, obs(), e.v); end
        end
        checks++;
        if (entry_count !== 8'(exp_cnt)) begin
            errors++;
            $display("FAIL entry_count_saturated actual=%0d required=%0d", entry_count, exp_cnt);
        end
        dbgrq = 1'b0; instr_done = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ext_entry();
        test_restart();
        test_bkpt();
        test_timeout();
        test_ignored();
        test_rst_mid_drain();
        test_back_to_back();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover actual=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
